uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Simple UART transmitter for the chip's 64-bit packet link; the companion to the on-chip UART receiver.
- Serializes one WIDTH-bit packet per frame at one bit per clk: start bit 0, data LSB-first, one stop bit 1. The line idles high.
- Optionally overwrites the MSB with an odd-parity bit.
- Double-buffered (holding register plus shift register) so the packet source can queue the next word while the current one shifts, giving back-to-back frames with no idle gap.

Parameters:
WIDTH, 64, packet width in bits including the parity bit at WIDTH-1 (legal range 2..254).

Ports:
clk  input  1  transmit clock; one serial bit per cycle
reset  input  1  synchronous, active-high reset
tx_data  input  WIDTH  packet to send (bits 1:0 declaration, 9:2 chip id, ... per packet definition)
ld_tx_data  input  1  load strobe; accepted only when tx_empty=1
gen_parity  input  1  sampled with ld_tx_data; 1 = replace bit WIDTH-1 with odd parity of bits WIDTH-2:0
tx_out  output  1  serial line; registered
tx_empty  output  1  high when the holding register is free
tx_busy  output  1  high while a frame (start/data/stop) is on the line
tx_overflow  output  1  one-cycle pulse when ld_tx_data arrives while tx_empty=0

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - tx_out=1, tx_empty=1, tx_busy=0, tx_overflow=0.
  - Holding and shift registers cleared; FSM goes to IDLE; bit counter set to 0.
  - Applies mid-frame too: the line returns high on the next cycle and any queued word is discarded.
- Load:
  - On a clk edge with ld_tx_data=1 and tx_empty=1, hold_reg is written and tx_empty=0 is registered.
  - If gen_parity=1, hold_reg[WIDTH-1] = ~^tx_data[WIDTH-2:0], so the total number of ones across all WIDTH bits is odd. Otherwise tx_data is stored verbatim.
  - ld_tx_data while tx_empty=0: the word is dropped, hold_reg is unchanged, and tx_overflow=1 for exactly one cycle.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
  - IDLE:
    - tx_out=1, tx_busy=0.
    - If hold_reg is full: shift_reg<=hold_reg, tx_empty<=1, tx_out<=0, tx_busy<=1, go to START.
  - START:
    - Start bit is on the line for 1 cycle.
    - Next: tx_out<=shift_reg[0], bit_cnt<=1, go to DATA.
  - DATA:
    - Each cycle, drive the next bit LSB-first: tx_out<=shift_reg[bit_cnt], bit_cnt<=bit_cnt+1.
    - After bit WIDTH-1 has been driven for one cycle: tx_out<=1, go to STOP.
    - bit_cnt is 8 bits wide and never wraps within a frame.
  - STOP:
    - Stop bit is on the line for exactly 1 cycle.
    - If hold_reg is full: start the next frame directly, with the same transfer actions as IDLE, and go to START (back-to-back frames).
    - Else: tx_busy<=0, go to IDLE.
- Frame length is WIDTH+2 cycles.
- Latency: ld_tx_data sampled at edge E0 in IDLE → start bit visible in the cycle after edge E1 → data bit k visible after edge E2+k → stop bit after edge E2+WIDTH.
- tx_empty:
  - Rises on the same edge the shifter takes the word, so the next word may be loaded during the current frame.
  - A load and a transfer never coincide, because a transfer requires tx_empty=0.
- Receiver compatibility:
  - A receiver sampling one bit per clk (2-flop synchronizer, start detect on low) captures bit k correctly.
  - One stop bit is enough for it to re-arm before the next start bit.

Test Plan:
- Reset then idle 10 cycles → tx_out=1, tx_empty=1, tx_busy=0 throughout.
- Load 64'h0000_0000_0000_0001, gen_parity=0 → tx_out sequence 0,1, then 63 zeros, then 1 (stop); tx_busy high for exactly 66 cycles; tx_empty low for exactly 1 cycle (hold stage only).
- Load 64'h0000_0000_0000_0003 with gen_parity=1 → transmitted bit 63 = 1 (two data ones → even → parity 1). Looped back into the UART receiver: rx_data matches and parity_error=0. With gen_parity=0 and bit63=0, the receiver flags parity_error=1.
- Load A=64'hA5A5_5A5A_0F0F_F0F0, then B=64'h0123_4567_89AB_CDEF during A's DATA phase → B's start bit immediately follows A's single stop bit (no idle); 132 consecutive busy cycles; loopback receiver yields A then B.
- Load A; load B mid-frame; load C while B is still pending → tx_overflow pulses 1 cycle on C's edge; only A and B are transmitted.
- Assert reset at data bit 30 of a frame with a word queued → next cycle tx_out=1, tx_busy=0, tx_empty=1; no further frame is emitted.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: double-buffered UART transmitter, one serial bit per clk.
// Frame = start(0), WIDTH data bits LSB-first, stop(1). Line idles high.
// Optional odd parity replaces the packet MSB at load time.
module uart_tx #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ld_tx_data,
  input  logic             gen_parity,
  output logic             tx_out,
  output logic             tx_empty,
  output logic             tx_busy,
  output logic             tx_overflow
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] load_word_c;

  // Word written into the holding register, with optional odd parity in the MSB.
  always_comb begin
    load_word_c = tx_data;
    if (gen_parity) begin
      load_word_c[WIDTH-1] = ~^tx_data[WIDTH-2:0];
    end
  end

  // Holding register, frame sequencer and all registered outputs.
  // The shifter consumes shift_reg[0] each bit and shifts right, so bit_cnt
  // only counts how many data bits have been put on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_reg    <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      tx_out      <= 1'b1;
      tx_empty    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      tx_overflow <= ld_tx_data && !tx_empty;

      // Load and transfer are mutually exclusive: load needs tx_empty=1,
      // transfer needs tx_empty=0.
      if (ld_tx_data && tx_empty) begin
        hold_reg <= load_word_c;
        tx_empty <= 1'b0;
      end

      case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (!tx_empty) begin
            shift_reg <= hold_reg;
            tx_empty  <= 1'b1;
            tx_out    <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          tx_out    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= CNT_W'(1);
          state     <= DATA;
        end

        DATA: begin
          if (bit_cnt == LAST_CNT) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end else begin
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= CNT_W'(bit_cnt + CNT_W'(1));
          end
        end

        STOP: begin
          // A queued word starts immediately after the single stop bit.
          if (!tx_empty) begin
            shift_reg <= hold_reg;
            tx_empty  <= 1'b1;
            tx_out    <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end else begin
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: directed bench for uart_tx with a loopback receiver model.
module tb_uart_tx;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         ld_tx_data = 1'b0;
  logic         gen_parity = 1'b0;
  logic         tx_out;
  logic         tx_empty;
  logic         tx_busy;
  logic         tx_overflow;

  int checks = 0;
  int errors = 0;

  uart_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .ld_tx_data (ld_tx_data),
    .gen_parity (gen_parity),
    .tx_out     (tx_out),
    .tx_empty   (tx_empty),
    .tx_busy    (tx_busy),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Loopback receiver model and run-length monitors, sampled on the falling edge.
  logic         in_frame = 1'b0;
  int           idx = 0;
  logic [W-1:0] sh = '0;
  logic [W-1:0] rxq[$];
  logic         perr_q[$];
  logic         stop_err = 1'b0;
  int           busy_cur = 0, busy_last = 0;
  int           empty_cur = 0, empty_last = 0;
  int           ovf_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      idx      = 0;
    end else if (!in_frame) begin
      if (tx_out === 1'b0) begin
        in_frame = 1'b1;
        idx      = 0;
      end
    end else if (idx < int'(W)) begin
      sh[idx] = tx_out;
      idx++;
    end else begin
      if (tx_out !== 1'b1) stop_err = 1'b1;
      rxq.push_back(sh);
      perr_q.push_back(~^sh);
      in_frame = 1'b0;
    end

    if (tx_busy === 1'b1) busy_cur++;
    else if (busy_cur > 0) begin
      busy_last = busy_cur;
      busy_cur  = 0;
    end

    if (tx_empty === 1'b0) empty_cur++;
    else if (empty_cur > 0) begin
      empty_last = empty_cur;
      empty_cur  = 0;
    end

    if (tx_overflow === 1'b1) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] d, input logic p);
    tx_data    = d;
    gen_parity = p;
    ld_tx_data = 1'b1;
    tick();
    ld_tx_data = 1'b0;
    gen_parity = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (rxq.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("frame_timeout", 64'(rxq.size() >= n), 64'd1);
  endtask

  task automatic clear_rx();
    rxq.delete();
    perr_q.delete();
  endtask

  localparam logic [W-1:0] A = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [W-1:0] B = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] C = 64'hDEAD_BEEF_CAFE_F00D;

  initial begin
    int busy_seen;
    int ovf0;

    // Reset then idle.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", 64'({tx_out, tx_empty, tx_busy, tx_overflow}), 64'b1100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", 64'({tx_out, tx_empty, tx_busy, tx_overflow}), 64'b1100);
    end

    // Single frame carrying 1, no parity.
    clear_rx();
    load(64'h1, 1'b0);
    check("t2_hold", 64'({tx_empty, tx_busy, tx_out}), 64'b001);
    tick();
    check("t2_start", 64'({tx_out, tx_busy, tx_empty}), 64'b011);
    tick();
    check("t2_bit0", 64'(tx_out), 64'd1);
    tick();
    check("t2_bit1", 64'(tx_out), 64'd0);
    wait_frames(1, 100);
    repeat (3) tick();
    check("t2_word", rxq[0], 64'h1);
    check("t2_busy_len", 64'(busy_last), 64'd66);
    check("t2_empty_low", 64'(empty_last), 64'd1);
    check("t2_stop", 64'(stop_err), 64'd0);

    // Odd parity generated, then omitted.
    clear_rx();
    load(64'h3, 1'b1);
    wait_frames(1, 100);
    repeat (3) tick();
    check("t3_par_word", rxq[0], 64'h8000_0000_0000_0003);
    check("t3_par_ok", 64'(perr_q[0]), 64'd0);
    clear_rx();
    load(64'h3, 1'b0);
    wait_frames(1, 100);
    repeat (3) tick();
    check("t3_nopar_word", rxq[0], 64'h3);
    check("t3_nopar_err", 64'(perr_q[0]), 64'd1);

    // Back-to-back frames.
    clear_rx();
    load(A, 1'b0);
    repeat (10) tick();
    check("t4_empty_in_data", 64'(tx_empty), 64'd1);
    load(B, 1'b0);
    wait_frames(2, 300);
    repeat (3) tick();
    check("t4_word_a", rxq[0], A);
    check("t4_word_b", rxq[1], B);
    check("t4_busy_len", 64'(busy_last), 64'd132);
    check("t4_stop", 64'(stop_err), 64'd0);

    // Overflow while a word is already queued.
    clear_rx();
    ovf0 = ovf_cnt;
    load(A, 1'b0);
    repeat (10) tick();
    load(B, 1'b0);
    repeat (5) tick();
    load(C, 1'b0);
    check("t5_ovf_pulse", 64'(tx_overflow), 64'd1);
    check("t5_still_full", 64'(tx_empty), 64'd0);
    tick();
    check("t5_ovf_clear", 64'(tx_overflow), 64'd0);
    wait_frames(2, 300);
    repeat (80) tick();
    check("t5_frame_count", 64'(rxq.size()), 64'd2);
    check("t5_word_a", rxq[0], A);
    check("t5_word_b", rxq[1], B);
    check("t5_ovf_count", 64'(ovf_cnt - ovf0), 64'd1);

    // Reset in the middle of data bit 30 with a word queued.
    clear_rx();
    load(A, 1'b0);          // E0
    repeat (5) tick();      // E1..E5
    load(B, 1'b0);          // E6
    repeat (26) tick();     // E32: data bit 30 on the line
    check("t6_pre_busy", 64'({tx_busy, tx_empty}), 64'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_after_reset", 64'({tx_out, tx_busy, tx_empty}), 64'b101);
    busy_seen = 0;
    repeat (150) begin
      tick();
      if (tx_busy !== 1'b0) busy_seen++;
    end
    check("t6_no_busy", 64'(busy_seen), 64'd0);
    check("t6_no_frames", 64'(rxq.size()), 64'd0);
    check("t6_line_high", 64'(tx_out), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
